// File: rtl/alu_issue_if.sv
// Bundle of the issue stage's request, external-ALU and result signals.
// The slave modport is the stage's view; the master modport is the environment's view.
interface alu_issue_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_funct;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [4:0]       in_rd;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_z;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic [4:0]       out_rd;
    logic             out_err;
    logic [15:0]      ops_done;

    modport slave (
        input  in_valid, in_funct, in_a, in_b, in_rd, alu_z, out_ready,
        output in_ready, alu_a, alu_b, alu_op,
        output out_valid, out_result, out_zero, out_rd, out_err, ops_done
    );

    modport master (
        output in_valid, in_funct, in_a, in_b, in_rd, alu_z, out_ready,
        input  in_ready, alu_a, alu_b, alu_op,
        input  out_valid, out_result, out_zero, out_rd, out_err, ops_done
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Single-slot issue stage for MIPS R-type ALU ops: decodes funct, drives an
// external combinational ALU for one cycle, then holds the result until taken.
module alu_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [4:0]       rd_q, rd_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic             out_err_q, out_err_d;
    logic [15:0]      ops_done_q, ops_done_d;
    logic             live_q;

    logic       in_ready;
    logic       accept;
    logic       retire;
    logic [2:0] dec_op;
    logic       dec_err;

    always_comb begin
        dec_op  = OP_AND;
        dec_err = 1'b0;
        case (bus.in_funct)
            6'h24:   dec_op = OP_AND;
            6'h25:   dec_op = OP_OR;
            6'h20:   dec_op = OP_ADD;
            6'h22:   dec_op = OP_SUB;
            6'h2A:   dec_op = OP_SLT;
            default: dec_err = 1'b1;
        endcase
    end

    // live_q keeps in_ready low during reset and raises it on the first edge after release.
    assign in_ready = live_q && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;
    assign retire   = (state_q == DONE) && bus.out_ready;

    // NOTE: every variable gets its default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rd_d       = rd_q;
        err_d      = err_q;
        res_d      = res_q;
        zero_d     = zero_q;
        out_rd_d   = out_rd_q;
        out_err_d  = out_err_q;
        ops_done_d = retire ? ops_done_q + 16'd1 : ops_done_q;

        if (accept) begin
            op_d  = dec_op;
            a_d   = bus.in_a;
            b_d   = bus.in_b;
            rd_d  = bus.in_rd;
            err_d = dec_err;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                res_d     = err_q ? '0 : bus.alu_z;
                zero_d    = (res_d == '0);
                out_rd_d  = rd_q;
                out_err_d = err_q;
                state_d   = DONE;
            end
            DONE: begin
                // A retiring result may hand its slot straight to the next request.
                if (retire) state_d = accept ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            err_q      <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            out_rd_q   <= '0;
            out_err_q  <= 1'b0;
            ops_done_q <= '0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            out_rd_q   <= out_rd_d;
            out_err_q  <= out_err_d;
            ops_done_q <= ops_done_d;
            live_q     <= 1'b1;
        end
    end

    // ALU operands come only from the latched request, never from the live inputs.
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_err    = out_err_q;
    assign bus.ops_done   = ops_done_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed plus randomized bench for alu_issue_stage; an external ALU and the
// expected results are both modelled here from the funct/op definitions.
module tb_alu_issue_stage;
    logic clk;
    logic rst_n;

    alu_issue_if #(.WIDTH(32)) bus ();

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          vectors;
    int          miscompares;
    logic [15:0] cnt;
    logic [5:0]  funct_tab [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (bus.alu_op)
            3'b000:  bus.alu_z = bus.alu_a & bus.alu_b;
            3'b001:  bus.alu_z = bus.alu_a | bus.alu_b;
            3'b010:  bus.alu_z = bus.alu_a + bus.alu_b;
            3'b110:  bus.alu_z = bus.alu_a - bus.alu_b;
            3'b111:  bus.alu_z = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            default: bus.alu_z = 32'd0;
        endcase
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: what the stage must report for a request, straight from the funct table.
    function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e, output logic [2:0] o);
        e = 1'b0;
        o = 3'b000;
        r = 32'd0;
        case (f)
            6'h24:   begin r = a & b; o = 3'b000; end
            6'h25:   begin r = a | b; o = 3'b001; end
            6'h20:   begin r = a + b; o = 3'b010; end
            6'h22:   begin r = a - b; o = 3'b110; end
            6'h2A:   begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; o = 3'b111; end
            default: e = 1'b1;
        endcase
    endfunction

    // One request from IDLE through retirement; out_ready held low for `stall` cycles in DONE.
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int stall);
        logic [31:0] er;
        logic        ee;
        logic [2:0]  eo;
        int          n;
        ref_op(f, a, b, er, ee, eo);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_funct  = f;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_rd     = rd;
        bus.out_ready = (stall == 0);
        n = 0;
        while (!bus.in_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        check("exec_out_valid", 32'(bus.out_valid), 32'd0);
        check("exec_alu_a", bus.alu_a, a);
        check("exec_alu_b", bus.alu_b, b);
        if (!ee) check("exec_alu_op", 32'(bus.alu_op), 32'(eo));
        @(negedge clk);
        check("done_out_valid", 32'(bus.out_valid), 32'd1);
        check("done_result", bus.out_result, er);
        check("done_zero", 32'(bus.out_zero), 32'(er == 32'd0));
        check("done_rd", 32'(bus.out_rd), 32'(rd));
        check("done_err", 32'(bus.out_err), 32'(ee));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_result", bus.out_result, er);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_alu_a", bus.alu_a, a);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        cnt++;
        check("retire_ops_done", 32'(bus.ops_done), 32'(cnt));
        check("retire_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] er;
        logic        ee;
        logic [2:0]  eo;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        vectors      = 0;
        miscompares  = 0;
        cnt          = 16'd0;
        funct_tab    = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A};
        bus.in_valid = 1'b0;
        bus.in_funct = 6'd0;
        bus.in_a     = 32'd0;
        bus.in_b     = 32'd0;
        bus.in_rd    = 5'd0;
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset values, with requests waiting on the inputs
        bus.in_valid = 1'b1;
        bus.in_funct = 6'h20;
        bus.in_a     = 32'h55;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.out_result, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        check("rst_err", 32'(bus.out_err), 32'd0);
        check("rst_ops_done", 32'(bus.ops_done), 32'd0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1 check("rel_in_ready_before_edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 check("rel_in_ready_after_edge", 32'(bus.in_ready), 32'd1);

        // ADD, SUB to zero, signed SLT, unsupported funct
        do_op(6'h20, 32'd7, 32'd5, 5'd3, 0);
        do_op(6'h22, 32'h1234, 32'h1234, 5'd4, 0);
        do_op(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd5, 0);
        do_op(6'h3F, 32'h8, 32'h9, 5'd6, 0);

        // Backpressure, then same-edge retire and accept
        ref_op(6'h25, 32'hA5A5_0000, 32'h0000_5A5A, er, ee, eo);
        do_op(6'h24, 32'hFF, 32'h0F, 5'd8, 5);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_funct  = 6'h25;
        bus.in_a      = 32'hA5A5_0000;
        bus.in_b      = 32'h0000_5A5A;
        bus.in_rd     = 5'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result", bus.out_result, er);
            check("bp_rd", 32'(bus.out_rd), 32'd9);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_funct  = 6'h20;
        bus.in_a      = 32'd100;
        bus.in_b      = 32'd23;
        bus.in_rd     = 5'd17;
        #1 check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        cnt++;
        check("b2b_ops_done", 32'(bus.ops_done), 32'(cnt));
        check("b2b_exec_valid", 32'(bus.out_valid), 32'd0);
        check("b2b_alu_a", bus.alu_a, 32'd100);
        check("b2b_alu_op", 32'(bus.alu_op), 32'b010);
        @(negedge clk);
        check("b2b_done_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_result", bus.out_result, 32'd123);
        check("b2b_rd", 32'(bus.out_rd), 32'd17);
        @(negedge clk);
        cnt++;
        check("b2b_retire", 32'(bus.ops_done), 32'(cnt));

        // Reset during EXEC discards the request
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_funct = 6'h20;
        bus.in_a     = 32'd1;
        bus.in_b     = 32'd2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid_in_exec", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b0;
        cnt = 16'd0;
        #1;
        check("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_ops_done", 32'(bus.ops_done), 32'd0);
        check("mid_alu_a", bus.alu_a, 32'd0);
        @(negedge clk);
        check("mid_still_idle", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("mid_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_no_retire", 32'(bus.ops_done), 32'd0);
        do_op(6'h24, 32'h0000_F0F0, 32'h0000_FF00, 5'd1, 0);

        // Randomized requests, including invalid functs and stalls
        for (int k = 0; k < 40; k++) begin
            f = ($urandom_range(0, 5) == 5) ? 6'($urandom) : funct_tab[$urandom_range(0, 4)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            do_op(f, a, b, 5'($urandom), int'($urandom_range(0, 2)));
        end

        // Counter wrap: preload near the top, then two more results
        @(negedge clk);
        force dut.ops_done_q = 16'hFFFE;
        @(negedge clk);
        release dut.ops_done_q;
        cnt = 16'hFFFE;
        #1 check("wrap_preload", 32'(bus.ops_done), 32'hFFFE);
        do_op(6'h20, 32'd1, 32'd1, 5'd2, 0);
        do_op(6'h3F, 32'd3, 32'd4, 5'd7, 1);
        check("wrap_zero", 32'(bus.ops_done), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
